// File: rtl/wb_load_queue.sv
// In-order write-back queue: buffers MEM-stage results, aligns load data, retires one per cycle.
// Optional feature macro WB_LWLR_EN makes sizes 4/5 (LWL/LWR word merges) legal loads.
module wb_load_queue #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic                        mem_is_load,
  input  logic                        mem_sign_ext,
  input  logic [2:0]                  mem_size,
  input  logic [$clog2(DATA_W/8)-1:0] mem_addr_low,
  input  logic [DATA_W-1:0]           mem_result,
  input  logic                        mem_reg_we,
  input  logic [REG_ADDR_W-1:0]       mem_reg_waddr,
  input  logic [ADDR_W-1:0]           mem_pc,
  input  logic                        rdata_valid,
  output logic                        rdata_ready,
  input  logic [DATA_W-1:0]           rdata,
  output logic                        wb_valid,
  output logic                        wb_reg_we,
  output logic [REG_ADDR_W-1:0]       wb_reg_waddr,
  output logic [DATA_W-1:0]           wb_reg_wdata,
  output logic                        wb_misalign,
  output logic [ADDR_W-1:0]           debug_pc,
  output logic [DATA_W/8-1:0]         debug_wen
);
  localparam int NB     = DATA_W / 8;
  localparam int AL_W   = $clog2(NB);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = CNT_W + 3;

  typedef struct packed {
    logic                  is_load;
    logic                  sign_ext;
    logic [2:0]            size;
    logic [AL_W-1:0]       addr_low;
    logic [DATA_W-1:0]     result;
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_waddr;
    logic [ADDR_W-1:0]     pc;
    logic                  bad;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                head, enq_entry;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, idx;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d, good_in_q;
  logic                  enq_bad, nonempty, full, head_good, drop_busy, enq, retire;
  logic [DATA_W-1:0]     shifted, lane_mask, load_data;
  logic                  sign_bit;

  logic                  wb_valid_q, wb_valid_d, wb_reg_we_q, wb_reg_we_d;
  logic                  wb_misalign_q, wb_misalign_d;
  logic [REG_ADDR_W-1:0] wb_reg_waddr_q, wb_reg_waddr_d;
  logic [DATA_W-1:0]     wb_reg_wdata_q, wb_reg_wdata_d;
  logic [ADDR_W-1:0]     debug_pc_q, debug_pc_d;
  logic [NB-1:0]         debug_wen_q, debug_wen_d;

  assign head      = mem_q[head_q];
  assign nonempty  = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_good = head.is_load & ~head.bad;
  assign drop_busy = (drop_cnt_q != '0);

  assign mem_ready   = resetn & ~full;
  assign rdata_ready = drop_busy | (nonempty & head_good & ~flush);
  // While stale responses are pending they are never handed to the head load.
  assign retire = nonempty & ~flush & (~head_good | (rdata_valid & ~drop_busy));
  assign enq    = mem_valid & mem_ready & ~flush;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    enq_bad = 1'b0;
    if (mem_is_load) begin
      case (mem_size)
        3'd0:    enq_bad = 1'b0;
        3'd1:    enq_bad = mem_addr_low[0];
        3'd2:    enq_bad = (mem_addr_low[1:0] != 2'd0);
        3'd3:    enq_bad = (DATA_W == 32) || (mem_addr_low != '0);
`ifdef WB_LWLR_EN
        3'd4,
        3'd5:    enq_bad = 1'b0;
`else
        3'd4,
        3'd5:    enq_bad = 1'b1;
`endif
        default: enq_bad = 1'b1;
      endcase
    end
    enq_entry = '{is_load: mem_is_load, sign_ext: mem_sign_ext, size: mem_size,
                  addr_low: mem_addr_low, result: mem_result, reg_we: mem_reg_we,
                  reg_waddr: mem_reg_waddr, pc: mem_pc, bad: enq_bad};
  end

  always_comb begin
    good_in_q = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && mem_q[idx].is_load && !mem_q[idx].bad)
        good_in_q = good_in_q + DROP_W'(1);
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_cnt_d = drop_cnt_q + good_in_q;
    end else begin
      if (enq)    tail_d = tail_q + PTR_W'(1);
      if (retire) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(retire);
    end
    if (drop_busy && rdata_valid) drop_cnt_d = drop_cnt_d - DROP_W'(1);
  end

`ifdef WB_LWLR_EN
  logic [31:0] word32, old32, merged;
  logic [4:0]  sh;
`endif

  always_comb begin
    shifted   = rdata >> {head.addr_low, 3'b000};
    lane_mask = '1;
    sign_bit  = shifted[DATA_W-1];
    case (head.size)
      3'd0:    begin lane_mask = DATA_W'(8'hFF);         sign_bit = shifted[7];  end
      3'd1:    begin lane_mask = DATA_W'(16'hFFFF);      sign_bit = shifted[15]; end
      3'd2:    begin lane_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: ;
    endcase
    load_data = (shifted & lane_mask) | ((head.sign_ext && sign_bit) ? ~lane_mask : '0);
`ifdef WB_LWLR_EN
    word32 = rdata[31:0];
    if (DATA_W == 64 && head.addr_low[AL_W-1]) word32 = rdata[DATA_W-1 -: 32];
    old32  = head.result[31:0];
    sh     = '0;
    merged = '0;
    if (head.size == 3'd4) begin
      sh        = {2'd3 - head.addr_low[1:0], 3'b000};
      merged    = (word32 << sh) | (old32 & ~(32'hFFFF_FFFF << sh));
      load_data = DATA_W'(signed'(merged));
    end else if (head.size == 3'd5) begin
      sh        = {head.addr_low[1:0], 3'b000};
      merged    = (word32 >> sh) | (old32 & ~(32'hFFFF_FFFF >> sh));
      load_data = DATA_W'(signed'(merged));
    end
`endif
  end

  always_comb begin
    wb_valid_d     = retire;
    wb_reg_we_d    = 1'b0;
    wb_reg_waddr_d = wb_reg_waddr_q;
    wb_reg_wdata_d = wb_reg_wdata_q;
    wb_misalign_d  = wb_misalign_q;
    debug_pc_d     = debug_pc_q;
    if (retire) begin
      wb_reg_waddr_d = head.reg_waddr;
      debug_pc_d     = head.pc;
      wb_misalign_d  = head.is_load & head.bad;
      if (head.is_load && head.bad) begin
        wb_reg_wdata_d = '0;
      end else begin
        wb_reg_we_d    = head.reg_we;
        wb_reg_wdata_d = head.is_load ? load_data : head.result;
      end
    end
    debug_wen_d = {NB{wb_reg_we_d}};
  end

  // NOTE: queue storage is deliberately not reset; only pointers and count qualify entries.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= enq_entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      drop_cnt_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_we_q    <= 1'b0;
      wb_reg_waddr_q <= '0;
      wb_reg_wdata_q <= '0;
      wb_misalign_q  <= 1'b0;
      debug_pc_q     <= '0;
      debug_wen_q    <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      drop_cnt_q     <= drop_cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_we_q    <= wb_reg_we_d;
      wb_reg_waddr_q <= wb_reg_waddr_d;
      wb_reg_wdata_q <= wb_reg_wdata_d;
      wb_misalign_q  <= wb_misalign_d;
      debug_pc_q     <= debug_pc_d;
      debug_wen_q    <= debug_wen_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_we    = wb_reg_we_q;
  assign wb_reg_waddr = wb_reg_waddr_q;
  assign wb_reg_wdata = wb_reg_wdata_q;
  assign wb_misalign  = wb_misalign_q;
  assign debug_pc     = debug_pc_q;
  assign debug_wen    = debug_wen_q;

endmodule

// File: tb/tb_wb_load_queue.sv
// Self-checking bench for wb_load_queue (DATA_W=32, DEPTH=4): vector table, directed
// multi-cycle sequences and random traffic against a queue-based reference model.
module tb_wb_load_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        flush, mem_valid, mem_ready, mem_is_load, mem_sign_ext, mem_reg_we;
  logic [2:0]  mem_size;
  logic [1:0]  mem_addr_low;
  logic [31:0] mem_result, mem_pc, rdata, wb_reg_wdata, debug_pc;
  logic [4:0]  mem_reg_waddr, wb_reg_waddr;
  logic        rdata_valid, rdata_ready, wb_valid, wb_reg_we, wb_misalign;
  logic [3:0]  debug_wen;

  wb_load_queue #(.DATA_W(32), .DEPTH(DEPTH), .REG_ADDR_W(5), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_is_load(mem_is_load), .mem_sign_ext(mem_sign_ext), .mem_size(mem_size),
    .mem_addr_low(mem_addr_low), .mem_result(mem_result), .mem_reg_we(mem_reg_we),
    .mem_reg_waddr(mem_reg_waddr), .mem_pc(mem_pc), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .rdata(rdata), .wb_valid(wb_valid), .wb_reg_we(wb_reg_we),
    .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata), .wb_misalign(wb_misalign),
    .debug_pc(debug_pc), .debug_wen(debug_wen));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush, mem_valid, is_load, sx;
    logic [2:0]  size;
    logic [1:0]  al;
    logic [31:0] result;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic        rdata_valid;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        mr, rr, v, we;
    logic [31:0] wdata;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        is_load, sx, we, bad;
    logic [2:0]  size;
    logic [1:0]  al;
    logic [31:0] result, pc;
    logic [4:0]  waddr;
  } mentry_t;

  int          errors = 0, checks = 0;
  mentry_t     mq[$];
  int          drop = 0;
  logic        ewv = 0, ewe = 0, emis = 0;
  logic [4:0]  ewaddr = '0;
  logic [31:0] ewdata = '0, epc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_bad(input logic is_load, input logic [2:0] size, input logic [1:0] al);
    if (!is_load) return 1'b0;
    case (size)
      3'd0: return 1'b0;
      3'd1: return (al % 2) != 0;
      3'd2: return al != 0;
      3'd3: return 1'b1;
`ifdef WB_LWLR_EN
      3'd4, 3'd5: return 1'b0;
`else
      3'd4, 3'd5: return 1'b1;
`endif
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input mentry_t e, input logic [31:0] word);
    logic [7:0]  b [4];
    logic [31:0] r, m;
    logic        fill;
    int          n, o;
    o = int'(e.al);
    if (e.size == 3'd4) begin
      m = 32'hFFFF_FFFF << (8 * (3 - o));
      return (word << (8 * (3 - o))) | (e.result & ~m);
    end
    if (e.size == 3'd5) begin
      m = 32'hFFFF_FFFF >> (8 * o);
      return (word >> (8 * o)) | (e.result & ~m);
    end
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    n = 1 << e.size;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = b[o + i];
    fill = e.sx && r[8*n-1];
    for (int i = n; i < 4; i++) r[8*i +: 8] = {8{fill}};
    return r;
  endfunction

  function automatic in_t idle_in();
    in_t s;
    s = '0;
    return s;
  endfunction

  function automatic in_t ld_in(input logic [2:0] size, input logic [1:0] al, input logic sx,
                                input logic [4:0] wa);
    in_t s;
    s = '0;
    s.mem_valid = 1'b1; s.is_load = 1'b1; s.size = size; s.al = al; s.sx = sx;
    s.we = 1'b1; s.waddr = wa; s.pc = 32'h1000 + 32'(wa) * 4;
    return s;
  endfunction

  function automatic in_t nl_in(input logic [31:0] result, input logic [4:0] wa);
    in_t s;
    s = '0;
    s.mem_valid = 1'b1; s.result = result; s.we = 1'b1; s.waddr = wa;
    s.pc = 32'h2000 + 32'(wa) * 4;
    return s;
  endfunction

  function automatic in_t rsp_in(input logic [31:0] data);
    in_t s;
    s = '0;
    s.rdata_valid = 1'b1; s.rdata = data;
    return s;
  endfunction

  function automatic vec_t mkv(input in_t s, input logic mr, input logic rr, input logic v,
                               input logic we, input logic [31:0] wd, input logic mis);
    vec_t x;
    x.in = s; x.mr = mr; x.rr = rr; x.v = v; x.we = we; x.wdata = wd; x.mis = mis;
    return x;
  endfunction

  task automatic drive(input in_t s);
    flush = s.flush; mem_valid = s.mem_valid; mem_is_load = s.is_load; mem_sign_ext = s.sx;
    mem_size = s.size; mem_addr_low = s.al; mem_result = s.result; mem_reg_we = s.we;
    mem_reg_waddr = s.waddr; mem_pc = s.pc; rdata_valid = s.rdata_valid; rdata = s.rdata;
  endtask

  // One clock cycle, entered and left on a falling edge; the model advances alongside.
  task automatic step(input in_t s, output logic obs_mr, output logic obs_rr);
    logic    exp_mr, exp_rr, consumed, ret;
    int      drop_before, goods;
    mentry_t h, ne;
    drive(s);
    #1;
    exp_mr = (mq.size() < DEPTH);
    exp_rr = (drop != 0) || (mq.size() > 0 && mq[0].is_load && !mq[0].bad && !s.flush);
    obs_mr = mem_ready;
    obs_rr = rdata_ready;
    check("mem_ready", mem_ready, exp_mr);
    check("rdata_ready", rdata_ready, exp_rr);
    consumed    = s.rdata_valid && exp_rr;
    drop_before = drop;
    ret         = 1'b0;
    if (mq.size() > 0 && !s.flush) begin
      h = mq[0];
      if (!h.is_load || h.bad) ret = 1'b1;
      else if (consumed && drop_before == 0) ret = 1'b1;
    end
    ewv = ret;
    ewe = 1'b0;
    if (ret) begin
      ewaddr = h.waddr;
      epc    = h.pc;
      if (h.is_load && h.bad) begin ewdata = '0; emis = 1'b1; end
      else begin
        ewe    = h.we;
        ewdata = h.is_load ? ref_load(h, s.rdata) : h.result;
        emis   = 1'b0;
      end
      void'(mq.pop_front());
    end
    if (s.flush) begin
      goods = 0;
      foreach (mq[i]) if (mq[i].is_load && !mq[i].bad) goods++;
      drop = drop + goods;
      mq.delete();
    end
    if (consumed && drop_before != 0) drop = drop - 1;
    if (s.mem_valid && exp_mr && !s.flush) begin
      ne.is_load = s.is_load; ne.sx = s.sx; ne.we = s.we; ne.size = s.size; ne.al = s.al;
      ne.result = s.result; ne.pc = s.pc; ne.waddr = s.waddr;
      ne.bad = ref_bad(s.is_load, s.size, s.al);
      mq.push_back(ne);
    end
    @(posedge clk);
    @(negedge clk);
    check("wb_valid", wb_valid, ewv);
    check("wb_reg_we", wb_reg_we, ewe);
    check("wb_reg_waddr", wb_reg_waddr, ewaddr);
    check("wb_reg_wdata", wb_reg_wdata, ewdata);
    check("wb_misalign", wb_misalign, emis);
    check("debug_pc", debug_pc, epc);
    check("debug_wen", debug_wen, {4{ewe}});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [17];
    in_t        s;
    logic       mr, rr;
    logic [4:0] vbits;

    drive(idle_in());
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_ready", mem_ready, 1'b0);
    check("reset rdata_ready", rdata_ready, 1'b0);
    check("reset wb_valid", wb_valid, 1'b0);
    check("reset wb_reg_wdata", wb_reg_wdata, 32'h0);
    check("reset debug_wen", debug_wen, 4'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post-reset mem_ready", mem_ready, 1'b1);
    @(negedge clk);

    // Each row is one cycle: inputs, mem_ready/rdata_ready before the edge, wb_* after it.
    vt[0]  = mkv(ld_in(3'd0, 2'd2, 1'b1, 5'd3), 1, 0, 0, 0, 32'h0,        0);
    vt[1]  = mkv(rsp_in(32'h8899AABB),          1, 1, 1, 1, 32'hFFFFFF99, 0);
    vt[2]  = mkv(ld_in(3'd0, 2'd2, 1'b0, 5'd3), 1, 0, 0, 0, 32'hFFFFFF99, 0);
    vt[3]  = mkv(rsp_in(32'h8899AABB),          1, 1, 1, 1, 32'h00000099, 0);
    vt[4]  = mkv(ld_in(3'd2, 2'd1, 1'b0, 5'd4), 1, 0, 0, 0, 32'h00000099, 0);
    vt[5]  = mkv(nl_in(32'h1234, 5'd5),         1, 0, 1, 0, 32'h0,        1);
    vt[6]  = mkv(idle_in(),                     1, 0, 1, 1, 32'h1234,     0);
    vt[7]  = mkv(ld_in(3'd7, 2'd0, 1'b0, 5'd6), 1, 0, 0, 0, 32'h1234,     0);
    vt[8]  = mkv(idle_in(),                     1, 0, 1, 0, 32'h0,        1);
    vt[9]  = mkv(ld_in(3'd1, 2'd2, 1'b1, 5'd7), 1, 0, 0, 0, 32'h0,        1);
    vt[10] = mkv(rsp_in(32'h8899AABB),          1, 1, 1, 1, 32'hFFFF8899, 0);
    vt[11] = mkv(ld_in(3'd2, 2'd0, 1'b0, 5'd8), 1, 0, 0, 0, 32'hFFFF8899, 0);
    vt[12] = mkv(rsp_in(32'hDEADBEEF),          1, 1, 1, 1, 32'hDEADBEEF, 0);
    vt[13] = mkv(ld_in(3'd1, 2'd1, 1'b0, 5'd9), 1, 0, 0, 0, 32'hDEADBEEF, 0);
    vt[14] = mkv(rsp_in(32'hFFFFFFFF),          1, 0, 1, 0, 32'h0,        1);
    vt[15] = mkv(ld_in(3'd3, 2'd0, 1'b0, 5'd10),1, 0, 0, 0, 32'h0,        1);
    vt[16] = mkv(idle_in(),                     1, 0, 1, 0, 32'h0,        1);
    for (int i = 0; i < 17; i++) begin
      step(vt[i].in, mr, rr);
      check($sformatf("vec%0d mem_ready", i), mr, vt[i].mr);
      check($sformatf("vec%0d rdata_ready", i), rr, vt[i].rr);
      check($sformatf("vec%0d wb_valid", i), wb_valid, vt[i].v);
      check($sformatf("vec%0d wb_reg_we", i), wb_reg_we, vt[i].we);
      check($sformatf("vec%0d wb_reg_wdata", i), wb_reg_wdata, vt[i].wdata);
      check($sformatf("vec%0d wb_misalign", i), wb_misalign, vt[i].mis);
    end

    // Four back-to-back non-loads retire on four consecutive cycles, in order.
    vbits = '0;
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? nl_in(32'h100 + 32'(i), 5'(i + 1)) : idle_in(), mr, rr);
      vbits[i] = wb_valid;
      if (i > 0) check($sformatf("burst%0d data", i), wb_reg_wdata, 32'h100 + 32'(i - 1));
    end
    check("burst valid pattern", vbits, 5'b11110);

    // Fill with loads that get no response; a fifth offer sees mem_ready low.
    for (int i = 0; i < 4; i++) step(ld_in(3'd2, 2'd0, 1'b0, 5'(20 + i)), mr, rr);
    step(ld_in(3'd2, 2'd0, 1'b0, 5'd30), mr, rr);
    check("full mem_ready", mr, 1'b0);
    for (int i = 0; i < 4; i++) step(rsp_in($urandom), mr, rr);

    // Load then non-load with a late response: nothing retires until the load does.
    step(ld_in(3'd2, 2'd0, 1'b0, 5'd12), mr, rr);
    step(nl_in(32'h55, 5'd13), mr, rr);
    check("late head rdata_ready", rr, 1'b1);
    vbits = '0;
    for (int i = 0; i < 5; i++) begin
      step(idle_in(), mr, rr);
      vbits[i] = wb_valid;
    end
    check("late no retire", vbits, 5'b00000);
    step(rsp_in(32'hCAFEF00D), mr, rr);
    check("late load data", wb_reg_wdata, 32'hCAFEF00D);
    step(idle_in(), mr, rr);
    check("late nonload rdata_ready", rr, 1'b0);
    check("late nonload data", wb_reg_wdata, 32'h55);

    // Flush with two loads outstanding; their responses must be swallowed.
    step(ld_in(3'd2, 2'd0, 1'b0, 5'd14), mr, rr);
    step(ld_in(3'd2, 2'd0, 1'b0, 5'd15), mr, rr);
    s = idle_in(); s.flush = 1'b1;
    step(s, mr, rr);
    check("flush wb_valid", wb_valid, 1'b0);
    step(rsp_in(32'h1), mr, rr);
    check("drop1 rdata_ready", rr, 1'b1);
    step(rsp_in(32'h2), mr, rr);
    check("drop2 wb_valid", wb_valid, 1'b0);
    step(ld_in(3'd2, 2'd0, 1'b0, 5'd16), mr, rr);
    step(rsp_in(32'h3), mr, rr);
    check("post-flush load data", wb_reg_wdata, 32'h3);
    step(idle_in(), mr, rr);
    check("drop drained rdata_ready", rr, 1'b0);

`ifdef WB_LWLR_EN
    s = ld_in(3'd4, 2'd1, 1'b0, 5'd17); s.result = 32'hAABBCCDD;
    step(s, mr, rr);
    step(rsp_in(32'h11223344), mr, rr);
    check("LWL merge", wb_reg_wdata, 32'h3344CCDD);
    s = ld_in(3'd5, 2'd2, 1'b0, 5'd18); s.result = 32'hAABBCCDD;
    step(s, mr, rr);
    step(rsp_in(32'h11223344), mr, rr);
    check("LWR merge", wb_reg_wdata, 32'hAABB1122);
`else
    step(ld_in(3'd4, 2'd1, 1'b0, 5'd17), mr, rr);
    step(idle_in(), mr, rr);
    check("LWL disabled misalign", wb_misalign, 1'b1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      s = '0;
      s.flush       = ($urandom_range(0, 31) == 0);
      s.mem_valid   = 1'($urandom_range(0, 1));
      s.is_load     = 1'($urandom_range(0, 1));
      s.sx          = 1'($urandom_range(0, 1));
      s.size        = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      s.al          = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      s.result      = $urandom;
      s.we          = 1'($urandom_range(0, 1));
      s.waddr       = 5'($urandom_range(0, 31));
      s.pc          = $urandom;
      s.rdata_valid = 1'($urandom_range(0, 1));
      s.rdata       = $urandom;
      step(s, mr, rr);
    end

    // Reset in the middle of traffic clears everything.
    step(ld_in(3'd2, 2'd0, 1'b0, 5'd19), mr, rr);
    drive(idle_in());
    #2 resetn = 1'b0;
    #1;
    check("midreset mem_ready", mem_ready, 1'b0);
    check("midreset rdata_ready", rdata_ready, 1'b0);
    check("midreset wb_valid", wb_valid, 1'b0);
    check("midreset wb_reg_wdata", wb_reg_wdata, 32'h0);
    check("midreset debug_pc", debug_pc, 32'h0);
    mq.delete();
    drop = 0; ewv = 0; ewe = 0; emis = 0; ewaddr = '0; ewdata = '0; epc = '0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midreset release mem_ready", mem_ready, 1'b1);
    @(negedge clk);
    step(idle_in(), mr, rr);
    step(nl_in(32'h77, 5'd21), mr, rr);
    step(idle_in(), mr, rr);
    check("after reset nonload", wb_reg_wdata, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_load_queue.md
# wb_load_queue

In-order write-back queue with load alignment, placed between the MEM stage and the register file as the parametrised successor to the combinational WB stage. It buffers up to DEPTH completed MEM-stage instructions and waits on a valid/ready data-RAM response for each load. It extracts and sign- or zero-extends byte, half, word and (for 64-bit) dword lanes, then drives one registered register-file write per cycle in program order. It also absorbs pipeline flushes by discarding queued entries and the responses of loads already issued.

## Interface
Parameters:
- DATA_W, 32, datapath width; 32 or 64 only
- DEPTH, 4, queue entries; power of two, ≥2
- REG_ADDR_W, 5, register address width
- ADDR_W, 32, PC width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all queued entries
- mem_valid  in  1  MEM presents an instruction
- mem_ready  out  1  queue can accept
- mem_is_load  in  1  entry is a load
- mem_sign_ext  in  1  sign-extend load data
- mem_size  in  3  0 byte, 1 half, 2 word, 3 dword, 4 LWL, 5 LWR
- mem_addr_low  in  log2(DATA_W/8)  load address low bits
- mem_result  in  DATA_W  ALU result / old rt value for LWL/LWR
- mem_reg_we  in  1  register write enable
- mem_reg_waddr  in  REG_ADDR_W  destination
- mem_pc  in  ADDR_W  instruction PC
- rdata_valid  in  1  load data available
- rdata_ready  out  1  queue consumes load data
- rdata  in  DATA_W  full aligned RAM word
- wb_valid  out  1  retirement this cycle
- wb_reg_we  out  1  register-file write enable
- wb_reg_waddr  out  REG_ADDR_W  register-file address
- wb_reg_wdata  out  DATA_W  register-file data
- wb_misalign  out  1  retired load was misaligned/illegal
- debug_pc  out  ADDR_W  retired PC
- debug_wen  out  DATA_W/8  replicated wb_reg_we

## Operation
- Circular FIFO with head/tail pointers and occupancy count of log2(DEPTH)+1 bits. Entry fields: is_load, sign_ext, size, addr_low, result, reg_we, reg_waddr, pc, bad.
- bad is computed at enqueue when mem_is_load=1:
  - half requires addr_low[0]=0; word requires addr_low[1:0]=0; dword requires addr_low=0.
  - size 3 with DATA_W=32 is bad; sizes 6–7 are bad.
  - A bad load issues no RAM request.
- Enqueue when mem_valid & mem_ready. mem_ready = !full; no pass-through on full.
- Head retires when the queue is non-empty, flush=0 and one of the following holds:
  - non-load;
  - bad load;
  - good load with rdata_valid & rdata_ready.
- rdata_ready = (drop_cnt≠0) | (non-empty & head is good load & flush=0).
- Load extraction selects lane addr_low×size-bytes, then sign- or zero-extends to DATA_W.
- Writeback fields on retirement:
  - Bad load: wb_reg_we=0, wb_reg_wdata=0, wb_misalign=1.
  - Non-load: wb_reg_wdata=result.
- Flush:
  - Empties the queue (pointers and count to 0).
  - drop_cnt ← drop_cnt + (good loads in queue) − (1 if a response was consumed this cycle).
  - Responses accepted while drop_cnt≠0 are discarded and decrement drop_cnt; they never reach a queued load.
- An enqueue in the same cycle as flush is ignored (mem_ready remains as computed; the entry is lost, as MEM is being flushed too).

## Timing
- All wb_* and debug_* outputs are registered: retirement in cycle N gives wb_valid=1 in cycle N+1.
- Without retirement, wb_valid=0 and wb_reg_we=0 next cycle; the other wb_* outputs hold their values.
- Minimum latency is 2 cycles: enqueue at N, head at N+1, retire at N+1, visible at N+2.
- Throughput: one retirement per cycle.
- Reset value of every output is 0. Exception: mem_ready=1 once resetn is released; it is 0 while resetn is asserted.
- drop_cnt, pointers and count reset to 0.
- Reset mid-operation: all entries are lost. RAM responses in flight are the RAM side's responsibility (reset shared).
- Enqueue and retire in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.

## Configuration
- WB_LWLR_EN defined: sizes 4/5 are legal loads with any alignment. They operate on the 32-bit word selected by addr_low[2] (DATA_W=64) or on the whole word (DATA_W=32), with o = addr_low[1:0] and old = result[31:0]:
  - LWL = (word << 8(3−o)) | (old & ~(32'hFFFFFFFF << 8(3−o))).
  - LWR = (word >> 8o) | (old & ~(32'hFFFFFFFF >> 8o)).
  - For DATA_W=64, upper 32 bits are sign-extended from bit 31.
- WB_LWLR_EN undefined: sizes 4/5 are bad loads (suppressed write, wb_misalign=1).

## Test plan
- Byte load from RAM word 0x8899AABB, addr_low=2, sign_ext=1 → wb_reg_wdata=0xFFFFFF99. Zero-extended → 0x00000099.
- Four non-loads back-to-back → four consecutive wb_valid cycles in order. A fifth enqueue with DEPTH=4 and no retirement → mem_ready=0.
- Load then non-load; rdata_valid delayed 5 cycles → non-load retires only after the load. rdata_ready=1 only while the load is at head.
- Word load with addr_low=1 → no rdata_ready, wb_reg_we=0, wb_misalign=1, next entry retires following cycle.
- Two good loads queued, flush; then two responses 0x1, 0x2; then a new load with response 0x3 → the new load writes 0x3; drop_cnt returns to 0.
- WB_LWLR_EN: LWL o=1, word 0x11223344, old 0xAABBCCDD → 0x3344CCDD. LWR o=2, same inputs → 0xAABB1122.
